// File: rtl/pc_sequencer.sv
// Flow-control sequencer for a loadable program counter. Decodes the flow op every cycle and
// drives the counter's registered load/enable/address, with a small return-address stack.
module pc_sequencer #(
  parameter int                       ADDRESS_WIDTH = 8,
  parameter int                       STACK_DEPTH   = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [ADDRESS_WIDTH-1:0]         pc,
  input  logic [2:0]                       flow,
  input  logic [ADDRESS_WIDTH-1:0]         target,
  input  logic                             zero_flag,
  input  logic                             carry_flag,
  input  logic                             stall,
  input  logic                             resume,
  output logic                             load,
  output logic                             enable,
  output logic [ADDRESS_WIDTH-1:0]         address,
  output logic                             halted,
  output logic                             fault,
  output logic [$clog2(STACK_DEPTH):0]     stack_level
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [2:0] {
    F_NEXT = 3'd0, F_HOLD = 3'd1, F_JUMP = 3'd2, F_JZ = 3'd3,
    F_JC   = 3'd4, F_CALL = 3'd5, F_RET  = 3'd6, F_HALT = 3'd7
  } flow_e;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic                       load_q, load_d;
  logic                       enable_q, enable_d;
  logic [ADDRESS_WIDTH-1:0]   address_q, address_d;
  logic                       halted_q, halted_d;
  logic                       fault_q, fault_d;
  logic [LVL_W-1:0]           level_q, level_d;
  logic [ADDRESS_WIDTH-1:0]   stack_q [STACK_DEPTH];
  logic [ADDRESS_WIDTH-1:0]   stack_d [STACK_DEPTH];

  logic [ADDRESS_WIDTH-1:0]   ret_addr;
  logic [LVL_W-1:0]           level_m1;
  logic [PTR_W-1:0]           wr_idx, top_idx;
  logic                       stk_full, stk_empty;
  flow_e                      op;

  // Return address wraps naturally at the address width.
  assign ret_addr  = pc + {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
  assign level_m1  = level_q - LVL_W'(1);
  assign wr_idx    = level_q[PTR_W-1:0];
  assign top_idx   = level_m1[PTR_W-1:0];
  assign stk_full  = (level_q == LVL_W'(STACK_DEPTH));
  assign stk_empty = (level_q == '0);
  assign op        = flow_e'(flow);

  always_comb begin
    state_d   = state_q;
    load_d    = 1'b1;
    enable_d  = 1'b0;
    address_d = address_q;
    halted_d  = 1'b0;
    fault_d   = 1'b0;
    level_d   = level_q;
    stack_d   = stack_q;

    case (state_q)
      S_BOOT: begin
        load_d    = 1'b0;
        address_d = RESET_VECTOR;
        state_d   = S_RUN;
      end

      S_RUN: begin
        if (!stall) begin
          case (op)
            F_NEXT: enable_d = 1'b1;
            F_HOLD: ;
            F_JUMP: begin
              load_d    = 1'b0;
              address_d = target;
            end
            F_JZ: begin
              if (zero_flag) begin
                load_d    = 1'b0;
                address_d = target;
              end else begin
                enable_d = 1'b1;
              end
            end
            F_JC: begin
              if (carry_flag) begin
                load_d    = 1'b0;
                address_d = target;
              end else begin
                enable_d = 1'b1;
              end
            end
            F_CALL: begin
              if (stk_full) begin
                state_d = S_FAULT;
                fault_d = 1'b1;
              end else begin
                stack_d[wr_idx] = ret_addr;
                level_d         = level_q + LVL_W'(1);
                load_d          = 1'b0;
                address_d       = target;
              end
            end
            F_RET: begin
              if (stk_empty) begin
                state_d = S_FAULT;
                fault_d = 1'b1;
              end else begin
                level_d   = level_m1;
                load_d    = 1'b0;
                address_d = stack_q[top_idx];
              end
            end
            F_HALT: begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end
            default: ;
          endcase
        end
      end

      // Resume returns to RUN idle; the next flow op is decoded on the following edge.
      S_HALT: begin
        if (resume) state_d = S_RUN;
        else        halted_d = 1'b1;
      end

      S_FAULT: fault_d = 1'b1;

      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_BOOT;
      load_q    <= 1'b1;
      enable_q  <= 1'b0;
      address_q <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      level_q   <= '0;
      stack_q   <= '{default: '0};
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      enable_q  <= enable_d;
      address_q <= address_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
      level_q   <= level_d;
      stack_q   <= stack_d;
    end
  end

  assign load        = load_q;
  assign enable      = enable_q;
  assign address     = address_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign stack_level = level_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: stimulus pushes expected outputs, a monitor
// pops and compares them shortly after each rising edge.
module tb_pc_sequencer;

  localparam logic [2:0] NXT = 3'd0, HLD = 3'd1, JMP = 3'd2, JZ = 3'd3,
                         JC  = 3'd4, CAL = 3'd5, RET = 3'd6, HLT = 3'd7;

  logic       clock, reset;
  logic [7:0] pc, target, address;
  logic [2:0] flow, stack_level;
  logic       zero_flag, carry_flag, stall, resume;
  logic       load, enable, halted, fault;

  pc_sequencer #(.ADDRESS_WIDTH(8), .STACK_DEPTH(4), .RESET_VECTOR(8'h10)) dut (
    .clock(clock), .reset(reset), .pc(pc), .flow(flow), .target(target),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .stall(stall), .resume(resume),
    .load(load), .enable(enable), .address(address), .halted(halted), .fault(fault),
    .stack_level(stack_level)
  );

  typedef struct {
    logic       ld, en;
    logic [7:0] addr;
    logic       hlt, flt;
    logic [2:0] lvl;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk({e.name, ".load"},   32'(load),        32'(e.ld));
    chk({e.name, ".enable"}, 32'(enable),      32'(e.en));
    chk({e.name, ".addr"},   32'(address),     32'(e.addr));
    chk({e.name, ".halted"}, 32'(halted),      32'(e.hlt));
    chk({e.name, ".fault"},  32'(fault),       32'(e.flt));
    chk({e.name, ".level"},  32'(stack_level), 32'(e.lvl));
  endtask

  // Monitor: the registered outputs for each step are valid just after the following edge.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) chk_all(exp_q.pop_front());
    end
  end

  task automatic step(input logic rn, input logic st, input logic rs, input logic [2:0] f,
                      input logic [7:0] p, input logic [7:0] t, input logic z, input logic c,
                      input logic ld, input logic en, input logic [7:0] a,
                      input logic h, input logic fl, input logic [2:0] lv, input string nm);
    exp_t e;
    @(negedge clock);
    reset = rn; stall = st; resume = rs; flow = f; pc = p; target = t;
    zero_flag = z; carry_flag = c;
    e.ld = ld; e.en = en; e.addr = a; e.hlt = h; e.flt = fl; e.lvl = lv; e.name = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    reset = 1'b0; stall = 1'b0; resume = 1'b0; flow = NXT; pc = '0; target = '0;
    zero_flag = 1'b0; carry_flag = 1'b0;

    //   rn st rs flow pc     tgt    z  c   ld en addr   h  f  lvl  name
    step(0, 0, 0, NXT, 8'h00, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0, "reset");
    step(1, 0, 0, NXT, 8'h00, 8'h00, 0, 0,  0, 0, 8'h10, 0, 0, 0, "boot");
    step(1, 0, 0, NXT, 8'h10, 8'h00, 0, 0,  1, 1, 8'h10, 0, 0, 0, "next");
    step(1, 0, 0, JZ,  8'h11, 8'h40, 1, 0,  0, 0, 8'h40, 0, 0, 0, "jz_taken");
    step(1, 0, 0, JZ,  8'h40, 8'h77, 0, 1,  1, 1, 8'h40, 0, 0, 0, "jz_not");
    step(1, 0, 0, JC,  8'h41, 8'h55, 0, 1,  0, 0, 8'h55, 0, 0, 0, "jc_taken");
    step(1, 0, 0, JC,  8'h55, 8'h66, 1, 0,  1, 1, 8'h55, 0, 0, 0, "jc_not");
    step(1, 0, 0, HLD, 8'h56, 8'h00, 0, 0,  1, 0, 8'h55, 0, 0, 0, "hold");
    step(1, 0, 0, JMP, 8'h56, 8'h33, 0, 0,  0, 0, 8'h33, 0, 0, 0, "jump");
    step(1, 0, 0, CAL, 8'hFF, 8'h20, 0, 0,  0, 0, 8'h20, 0, 0, 1, "call_wrap");
    step(1, 0, 0, RET, 8'h20, 8'h99, 0, 0,  0, 0, 8'h00, 0, 0, 0, "ret_wrap");
    step(1, 1, 0, CAL, 8'h05, 8'h80, 0, 0,  1, 0, 8'h00, 0, 0, 0, "stall_call1");
    step(1, 1, 0, CAL, 8'h05, 8'h80, 0, 0,  1, 0, 8'h00, 0, 0, 0, "stall_call2");
    step(1, 0, 0, CAL, 8'h05, 8'h80, 0, 0,  0, 0, 8'h80, 0, 0, 1, "call_once");
    step(1, 0, 0, NXT, 8'h80, 8'h00, 0, 0,  1, 1, 8'h80, 0, 0, 1, "after_call");
    step(1, 0, 0, RET, 8'h81, 8'h00, 0, 0,  0, 0, 8'h06, 0, 0, 0, "ret_call");
    step(1, 0, 0, HLT, 8'h06, 8'h00, 0, 0,  1, 0, 8'h06, 1, 0, 0, "halt");
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, NXT, 8'h06, 8'h00, 0, 0, 1, 0, 8'h06, 1, 0, 0, "halt_hold");
    step(1, 1, 1, NXT, 8'h06, 8'h00, 0, 0,  1, 0, 8'h06, 0, 0, 0, "resume");
    step(1, 0, 0, NXT, 8'h06, 8'h00, 0, 0,  1, 1, 8'h06, 0, 0, 0, "resume_next");
    step(1, 0, 0, RET, 8'h07, 8'h00, 0, 0,  1, 0, 8'h06, 0, 1, 0, "ret_empty");
    step(1, 0, 0, NXT, 8'h07, 8'h00, 0, 0,  1, 0, 8'h06, 0, 1, 0, "fault_sticky");
    step(0, 0, 0, NXT, 8'h07, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0, "reset2");
    step(1, 0, 0, NXT, 8'h00, 8'h00, 0, 0,  0, 0, 8'h10, 0, 0, 0, "boot2");
    step(1, 0, 0, CAL, 8'h10, 8'hA0, 0, 0,  0, 0, 8'hA0, 0, 0, 1, "call1");
    step(1, 0, 0, CAL, 8'hA0, 8'hA1, 0, 0,  0, 0, 8'hA1, 0, 0, 2, "call2");
    step(1, 0, 0, CAL, 8'hA1, 8'hA2, 0, 0,  0, 0, 8'hA2, 0, 0, 3, "call3");
    step(1, 0, 0, CAL, 8'hA2, 8'hA3, 0, 0,  0, 0, 8'hA3, 0, 0, 4, "call4");
    step(1, 0, 0, CAL, 8'hA3, 8'hA4, 0, 0,  1, 0, 8'hA3, 0, 1, 4, "call_full");
    step(1, 0, 0, NXT, 8'hA3, 8'h00, 0, 0,  1, 0, 8'hA3, 0, 1, 4, "full_sticky");
    step(1, 0, 0, RET, 8'hA3, 8'h00, 0, 0,  1, 0, 8'hA3, 0, 1, 4, "full_ret");
    step(1, 0, 0, CAL, 8'h10, 8'h00, 0, 0,  1, 0, 8'hA3, 0, 1, 4, "full_call");

    // Asynchronous reset in the middle of a cycle, with a CALL presented.
    @(posedge clock);
    #3;
    flow = CAL; pc = 8'h12; target = 8'hC0;
    reset = 1'b0;
    #1;
    r.ld = 1'b1; r.en = 1'b0; r.addr = 8'h00; r.hlt = 1'b0; r.flt = 1'b0; r.lvl = 3'd0;
    r.name = "async_reset";
    chk_all(r);

    step(0, 0, 0, CAL, 8'h12, 8'hC0, 0, 0,  1, 0, 8'h00, 0, 0, 0, "reset_held");
    step(1, 0, 0, CAL, 8'h12, 8'hC0, 0, 0,  0, 0, 8'h10, 0, 0, 0, "boot3");
    step(1, 0, 0, RET, 8'h10, 8'h00, 0, 0,  1, 0, 8'h10, 0, 1, 0, "stack_cleared");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    #3;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Control-side driver for the processor's loadable program/microstep counter. Each cycle it decodes the flow-control field of the current instruction. It then drives the counter's active-low load, enable and load address, so the sequencer chooses and the counter executes. It holds a small return-address stack for CALL/RETURN, a reset-vector boot cycle, HALT, and a fault state for stack misuse.

Parameters:
ADDRESS_WIDTH, 8, width of the counter address and data.
STACK_DEPTH, 4, return-address stack entries (power of two, at least 2).
RESET_VECTOR, 0, address loaded into the counter on the first cycle after reset.

Ports:
clock  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
pc  input  ADDRESS_WIDTH  current counter value (counter data output).
flow  input  3  flow op: 0 NEXT, 1 HOLD, 2 JUMP, 3 JZ, 4 JC, 5 CALL, 6 RETURN, 7 HALT.
target  input  ADDRESS_WIDTH  branch/call destination.
zero_flag  input  1  ALU zero flag, sampled with flow.
carry_flag  input  1  ALU carry flag, sampled with flow.
stall  input  1  freeze request; while high, no flow op is consumed.
resume  input  1  leaves HALT (one-cycle pulse).
load  output  1  counter load, active low.
enable  output  1  counter increment enable.
address  output  ADDRESS_WIDTH  counter load address.
halted  output  1  high in HALT.
fault  output  1  high in FAULT.
stack_level  output  clog2(STACK_DEPTH)+1  current stack occupancy.

Behaviour:
- All outputs are registered, with no combinational path from inputs to outputs. A decision made at edge N appears after edge N and is consumed by the counter at edge N+1.
- Reset (asynchronous, while reset=0): state=BOOT, load=1, enable=0, address=0, halted=0, fault=0, stack empty, stack_level=0.
- BOOT, first edge after release: load=0, address=RESET_VECTOR, enable=0, then go to RUN. BOOT lasts exactly one cycle and ignores stall.
- RUN, stall=1: load=1, enable=0, nothing consumed, stack unchanged.
- RUN, stall=0, per flow:
  - NEXT: enable=1, load=1.
  - HOLD: enable=0, load=1.
  - JUMP: load=0, address=target, enable=0.
  - JZ: behaves as JUMP if zero_flag=1, else as NEXT. JC behaves the same way using carry_flag.
  - CALL: push pc+1 (modulo 2^ADDRESS_WIDTH, so it wraps at all-ones), then JUMP to target.
  - RETURN: pop the top entry, then load=0 with address=popped value.
  - HALT: load=1, enable=0, halted=1, go to HALT.
- load=0 and enable=1 are never driven in the same cycle. A load always takes priority in the decode.
- HALT: outputs idle (load=1, enable=0), flow ignored. On resume=1, leave HALT (halted=0, back to RUN) and resume with NEXT on the following edge. stall does not block resume.
- CALL with the stack full (stack_level=STACK_DEPTH), or RETURN with the stack empty: no push or pop, no load. Go to FAULT with fault=1 and outputs idle.
- FAULT is sticky and is left only through reset.
- Stack is LIFO. stack_level updates on the same edge as the push or pop.
- Reset asserted mid-operation (for example during a CALL) aborts immediately: the stack clears and BOOT repeats.

Test Plan:
- Reset release with RESET_VECTOR=8'h10 -> the cycle after release shows load=0, address=8'h10, enable=0. The next cycle, with flow=NEXT, shows enable=1, load=1.
- JZ with target=8'h40: zero_flag=1 -> load=0, address=8'h40. zero_flag=0 -> enable=1, load=1, address unchanged.
- CALL with pc=8'hFF, target=8'h20 -> load=0, address=8'h20, stack_level=1. A following RETURN -> load=0, address=8'h00 (wrap), stack_level=0.
- Five nested CALLs with STACK_DEPTH=4 -> the first four succeed (stack_level=4). The fifth gives fault=1, load=1, enable=0, and fault stays high until reset.
- flow=HALT -> halted=1, and flow=NEXT for 3 cycles gives enable=0. A resume pulse -> halted=0, then enable=1 on the next NEXT.
- stall=1 held over a CALL for 2 cycles -> no load and stack_level unchanged. Stall drop -> CALL executes exactly once. Asserting reset mid-sequence -> all outputs return to reset values asynchronously and stack_level=0.
